// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: pointer width, FSM state encoding
// and the modulo pointer increment used for sequential advance and return addresses.
package instr_sequencer_pkg;

  localparam int WORD_SIZE = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  function automatic logic [WORD_SIZE-1:0] ptr_inc(input logic [WORD_SIZE-1:0] p);
    return p + {{(WORD_SIZE-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Sequencer <-> fetch/execute bundle. The master side is the sequencer itself;
// the slave side is the fetch/execute environment.
interface instr_sequencer_if
  import instr_sequencer_pkg::*;
#(
  parameter int WIDTH = WORD_SIZE
) ();

  logic [WIDTH-1:0] pointer;
  logic             fetch_enable;
  logic             exec_done;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic             call;
  logic             ret;
  logic             halt;
  logic             halted;
  logic             stack_fault;

  modport master (
    output pointer, fetch_enable, halted, stack_fault,
    input  exec_done, branch_taken, branch_target, call, ret, halt
  );

  modport slave (
    input  pointer, fetch_enable, halted, stack_fault,
    output exec_done, branch_taken, branch_target, call, ret, halt
  );

endinterface

// File: rtl/instr_sequencer_call_stack.sv
// call_stack: LIFO of return addresses with combinational top-of-stack.
// Push when full and pop when empty are dropped; the parent turns those into a fault.
module instr_sequencer_call_stack
  import instr_sequencer_pkg::*;
#(
  parameter int WIDTH = WORD_SIZE,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] IDX_ONE  = PTR_W'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W:0]   r_count;
  logic [PTR_W-1:0] w_top_idx;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == FULL_CNT);
  assign empty     = (r_count == {(PTR_W+1){1'b0}});
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  // Low bits of a full count are zero, so the decrement wraps to DEPTH-1 as needed.
  assign w_top_idx = r_count[PTR_W-1:0] - IDX_ONE;
  assign dout      = r_mem[w_top_idx];

  // Occupancy counter; reset empties the stack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= {(PTR_W+1){1'b0}};
    end else if (w_do_push) begin
      r_count <= r_count + CNT_ONE;
    end else if (w_do_pop) begin
      r_count <= r_count - CNT_ONE;
    end else begin
      r_count <= r_count;
    end
  end

  // Entry storage; contents beyond the count are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_count[PTR_W-1:0]] <= din;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Program-counter / fetch sequencer: IDLE -> FETCH -> EXEC loop with halt, branch, call and return.
// Return stack and call/ret handling exist only when INSTR_SEQ_CALL_STACK_EN is defined.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter logic [WORD_SIZE-1:0] RESET_VECTOR = {WORD_SIZE{1'b0}},
  parameter int                   STACK_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_sequencer_if.master bus
);

  state_e               r_state;
  state_e               w_next_state;
  logic [WORD_SIZE-1:0] r_pointer;
  logic [WORD_SIZE-1:0] w_next_pointer;
  logic [WORD_SIZE-1:0] w_ret_addr;

  assign w_ret_addr = ptr_inc(r_pointer);

`ifdef INSTR_SEQ_CALL_STACK_EN
  logic                 w_push;
  logic                 w_pop;
  logic                 w_fault_set;
  logic                 w_stack_full;
  logic                 w_stack_empty;
  logic [WORD_SIZE-1:0] w_stack_top;
  logic                 r_fault;

  instr_sequencer_call_stack #(
    .WIDTH (WORD_SIZE),
    .DEPTH (STACK_DEPTH)
  ) u_call_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_ret_addr),
    .dout  (w_stack_top),
    .full  (w_stack_full),
    .empty (w_stack_empty)
  );

  // Sticky stack fault, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fault <= 1'b0;
    end else if (w_fault_set) begin
      r_fault <= 1'b1;
    end else begin
      r_fault <= r_fault;
    end
  end

  assign bus.stack_fault = r_fault;
`else
  localparam int unused_depth = STACK_DEPTH;
  logic w_unused_ctl;

  assign w_unused_ctl    = bus.call ^ bus.ret;
  assign bus.stack_fault = 1'b0;
`endif

  // State and pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_pointer <= RESET_VECTOR;
    end else begin
      r_state   <= w_next_state;
      r_pointer <= w_next_pointer;
    end
  end

  // Next state / next pointer; exactly one action per retired instruction.
  always_comb begin
    w_next_state   = r_state;
    w_next_pointer = r_pointer;
`ifdef INSTR_SEQ_CALL_STACK_EN
    w_push         = 1'b0;
    w_pop          = 1'b0;
    w_fault_set    = 1'b0;
`endif
    case (r_state)
      ST_IDLE:  w_next_state = ST_FETCH;
      ST_FETCH: w_next_state = ST_EXEC;
      ST_EXEC: begin
        if (bus.exec_done) begin
          if (bus.halt) begin
            w_next_state = ST_HALT;
`ifdef INSTR_SEQ_CALL_STACK_EN
          end else if (bus.ret) begin
            if (w_stack_empty) begin
              w_fault_set  = 1'b1;
              w_next_state = ST_HALT;
            end else begin
              w_pop          = 1'b1;
              w_next_pointer = w_stack_top;
              w_next_state   = ST_FETCH;
            end
          end else if (bus.call) begin
            if (w_stack_full) begin
              w_fault_set  = 1'b1;
              w_next_state = ST_HALT;
            end else begin
              w_push         = 1'b1;
              w_next_pointer = bus.branch_target;
              w_next_state   = ST_FETCH;
            end
`endif
          end else if (bus.branch_taken) begin
            w_next_pointer = bus.branch_target;
            w_next_state   = ST_FETCH;
          end else begin
            w_next_pointer = w_ret_addr;
            w_next_state   = ST_FETCH;
          end
        end else begin
          w_next_state = ST_EXEC;
        end
      end
      ST_HALT:  w_next_state = ST_HALT;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  assign bus.pointer      = r_pointer;
  assign bus.fetch_enable = (r_state == ST_FETCH);
  assign bus.halted       = (r_state == ST_HALT);

endmodule
